layer_mixer: RTL and testbench

Parametrised, pipelined layer compositor for the display path. Picks the highest-priority requesting layer out of NUM_LAYERS RGB sources per pixel, with an optional 50 % blend of the winner over the next requesting layer. A priority/enable/blend table is written at any time and takes effect only at a frame boundary. It sits between the per-layer pixel generators and the VGA timing/output stage.

---
 rtl/layer_mixer.sv | 164 ++++++++++++++++
 tb/tb_layer_mixer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_mixer.sv
// layer_mixer: picks the highest-ranked requesting layer per pixel, with an optional 50% blend over the runner-up.
// The rank/enable/blend table is double-buffered and swapped at frame_start. Output latency is two cycles.
module layer_mixer #(
    parameter int NUM_LAYERS = 4,
    parameter int CW = 8,
    parameter logic [3*CW-1:0] BG_COLOR = '0,
    localparam int LW = (NUM_LAYERS > 2) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pix_valid_in,
    input  logic [NUM_LAYERS-1:0]      req,
    input  logic [NUM_LAYERS*3*CW-1:0] rgb_in,
    input  logic                       frame_start,
    input  logic                       cfg_wr,
    input  logic [LW-1:0]              cfg_layer,
    input  logic [LW-1:0]              cfg_rank,
    input  logic                       cfg_en,
    input  logic                       cfg_blend,
    output logic                       cfg_pending,
    output logic [CW-1:0]              red,
    output logic [CW-1:0]              green,
    output logic [CW-1:0]              blue,
    output logic                       pix_valid_out,
    output logic [LW-1:0]              top_layer,
    output logic                       top_hit
);
    localparam int PW = 3 * CW;

    logic [LW-1:0]         sh_rank_q  [NUM_LAYERS];
    logic [LW-1:0]         act_rank_q [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] sh_en_q, sh_blend_q, act_en_q, act_blend_q;
    logic                  pend_q;
    logic                  wr_ok;

    assign wr_ok = cfg_wr && (int'(cfg_layer) < NUM_LAYERS);

    // Active takes the pre-write shadow when a write and a swap coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LAYERS; i++) begin
                sh_rank_q[i]  <= LW'(i);
                act_rank_q[i] <= LW'(i);
            end
            sh_en_q     <= '1;
            act_en_q    <= '1;
            sh_blend_q  <= '0;
            act_blend_q <= '0;
            pend_q      <= 1'b0;
        end else begin
            if (frame_start) begin
                act_rank_q  <= sh_rank_q;
                act_en_q    <= sh_en_q;
                act_blend_q <= sh_blend_q;
            end
            if (wr_ok) begin
                sh_rank_q[cfg_layer]  <= cfg_rank;
                sh_en_q[cfg_layer]    <= cfg_en;
                sh_blend_q[cfg_layer] <= cfg_blend;
            end
            pend_q <= wr_ok | (pend_q & ~frame_start);
        end
    end

    assign cfg_pending = pend_q;

    logic [PW-1:0]         pix [NUM_LAYERS];
    logic [NUM_LAYERS-1:0] cand;
    logic [LW-1:0]         win_idx, win_rank, run_idx, run_rank;
    logic                  win_hit, run_hit;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_pix
        assign pix[g] = rgb_in[g*PW +: PW];
    end

    assign cand = req & act_en_q;

    // Ascending scan with >= lets the higher index win equal ranks.
    always_comb begin
        win_idx  = '0;
        win_rank = '0;
        win_hit  = 1'b0;
        run_idx  = '0;
        run_rank = '0;
        run_hit  = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cand[i] && (!win_hit || act_rank_q[i] >= win_rank)) begin
                win_idx  = LW'(i);
                win_rank = act_rank_q[i];
                win_hit  = 1'b1;
            end
        end
        for (int i = 0; i < NUM_LAYERS; i++) begin
            if (cand[i] && LW'(i) != win_idx && (!run_hit || act_rank_q[i] >= run_rank)) begin
                run_idx  = LW'(i);
                run_rank = act_rank_q[i];
                run_hit  = 1'b1;
            end
        end
    end

    logic          s1_valid_q, s1_hit_q, s1_blend_q;
    logic [LW-1:0] s1_idx_q;
    logic [PW-1:0] s1_win_q, s1_under_q;
    logic [PW-1:0] s1_win_d, s1_under_d;
    logic          s1_blend_d;

    assign s1_win_d   = win_hit ? pix[win_idx] : BG_COLOR;
    assign s1_under_d = run_hit ? pix[run_idx] : BG_COLOR;
    assign s1_blend_d = win_hit & act_blend_q[win_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_hit_q   <= 1'b0;
            s1_blend_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_win_q   <= '0;
            s1_under_q <= '0;
        end else begin
            s1_valid_q <= pix_valid_in;
            s1_hit_q   <= win_hit;
            s1_blend_q <= s1_blend_d;
            s1_idx_q   <= win_idx;
            s1_win_q   <= s1_win_d;
            s1_under_q <= s1_under_d;
        end
    end

    logic [CW:0]   sum [3];
    logic [PW-1:0] avg;

    for (genvar c = 0; c < 3; c++) begin : g_avg
        assign sum[c] = {1'b0, s1_win_q[c*CW +: CW]} + {1'b0, s1_under_q[c*CW +: CW]};
        assign avg[c*CW +: CW] = sum[c][CW:1];
    end

    logic [PW-1:0] rgb_q, rgb_d;
    logic          pv_q, hit_q, hit_d;
    logic [LW-1:0] top_q, top_d;

    assign rgb_d = !s1_valid_q ? '0 : (s1_blend_q ? avg : s1_win_q);
    assign hit_d = s1_valid_q & s1_hit_q;
    assign top_d = hit_d ? s1_idx_q : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgb_q <= '0;
            pv_q  <= 1'b0;
            hit_q <= 1'b0;
            top_q <= '0;
        end else begin
            rgb_q <= rgb_d;
            pv_q  <= s1_valid_q;
            hit_q <= hit_d;
            top_q <= top_d;
        end
    end

    assign {red, green, blue} = rgb_q;
    assign pix_valid_out      = pv_q;
    assign top_hit            = hit_q;
    assign top_layer          = top_q;
endmodule

// File: tb/tb_layer_mixer.sv
// tb_layer_mixer: randomized and directed checks of layer_mixer against a rank-key reference model.
module tb_layer_mixer;
    localparam int N = 4;
    localparam logic [23:0] BG = 24'h010080;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid_in, frame_start, cfg_wr, cfg_en, cfg_blend;
    logic [3:0]  req;
    logic [95:0] rgb_in;
    logic [1:0]  cfg_layer, cfg_rank;
    logic        cfg_pending, pix_valid_out, top_hit;
    logic [7:0]  red, green, blue;
    logic [1:0]  top_layer;

    layer_mixer #(.NUM_LAYERS(N), .CW(8), .BG_COLOR(BG)) dut (
        .clk(clk), .rst(rst), .pix_valid_in(pix_valid_in), .req(req), .rgb_in(rgb_in),
        .frame_start(frame_start), .cfg_wr(cfg_wr), .cfg_layer(cfg_layer), .cfg_rank(cfg_rank),
        .cfg_en(cfg_en), .cfg_blend(cfg_blend), .cfg_pending(cfg_pending),
        .red(red), .green(green), .blue(blue), .pix_valid_out(pix_valid_out),
        .top_layer(top_layer), .top_hit(top_hit)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        v;
        logic        hit;
        logic [1:0]  top;
        logic [23:0] rgb;
    } px_t;

    int   checks = 0, errors = 0;
    int   sh_rank [N], ac_rank [N];
    logic sh_en [N], ac_en [N], sh_bl [N], ac_bl [N];
    logic m_pend;
    px_t  s1_e, out_e;
    px_t  got;

    assign got = {pix_valid_out, top_hit, top_layer, red, green, blue};

    // Priority key rank*N+index orders candidates exactly as the ranking rules demand.
    function automatic px_t model(input logic v, input logic [3:0] r, input logic [95:0] rgb);
        px_t p;
        int best = -1, sec = -1, bk = -1, sk = -1;
        logic [23:0] w, u;
        p = '0;
        for (int i = 0; i < N; i++) begin
            if (r[i] && ac_en[i]) begin
                int k = ac_rank[i] * N + i;
                if (k > bk) begin sec = best; sk = bk; best = i; bk = k; end
                else if (k > sk) begin sec = i; sk = k; end
            end
        end
        if (!v) return p;
        p.v = 1'b1;
        if (best < 0) begin p.rgb = BG; return p; end
        p.hit = 1'b1;
        p.top = 2'(best);
        w = rgb[best*24 +: 24];
        u = (sec >= 0) ? rgb[sec*24 +: 24] : BG;
        if (!ac_bl[best]) p.rgb = w;
        else for (int c = 0; c < 3; c++) p.rgb[c*8 +: 8] = 8'((int'(w[c*8 +: 8]) + int'(u[c*8 +: 8])) / 2);
        return p;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            sh_rank[i] = i; ac_rank[i] = i;
            sh_en[i] = 1'b1; ac_en[i] = 1'b1;
            sh_bl[i] = 1'b0; ac_bl[i] = 1'b0;
        end
        m_pend = 1'b0;
        s1_e = '0;
        out_e = '0;
    endtask

    task automatic step(input logic v, input logic [3:0] r, input logic fs, input logic wr,
                        input logic [1:0] l, input logic [1:0] rk, input logic e, input logic b);
        px_t nx;
        pix_valid_in = v; req = r; frame_start = fs; cfg_wr = wr;
        cfg_layer = l; cfg_rank = rk; cfg_en = e; cfg_blend = b;
        nx = model(v, r, rgb_in);
        @(posedge clk);
        out_e = s1_e;
        s1_e = nx;
        if (fs) for (int i = 0; i < N; i++) begin
            ac_rank[i] = sh_rank[i]; ac_en[i] = sh_en[i]; ac_bl[i] = sh_bl[i];
        end
        if (wr) begin sh_rank[l] = rk; sh_en[l] = e; sh_bl[l] = b; end
        m_pend = wr ? 1'b1 : (fs ? 1'b0 : m_pend);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);
        model_reset();
        checks++;
        if (got !== 30'h0 || cfg_pending !== 1'b0) begin
            errors++; $display("FAIL reset_outputs got %h/%b exp 0/0", got, cfg_pending);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        rgb_in = {24'hAAAAAA, 24'h112233, 24'h445566, 24'hFFFFFF};
        step(1, 4'b0101, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL basic_latency1 got %b exp 0", pix_valid_out); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (got !== out_e || got !== {1'b1, 1'b1, 2'd2, 24'h112233}) begin
            errors++; $display("FAIL basic_winner got %h exp %h", got, {1'b1, 1'b1, 2'd2, 24'h112233});
        end
    endtask

    task automatic test_bg_blank();
        step(1, 4'b0000, 0, 0, 0, 0, 0, 0);
        step(0, 4'b1111, 0, 0, 0, 0, 0, 0);
        checks++;
        if (got !== {1'b1, 1'b0, 2'd0, BG}) begin errors++; $display("FAIL background got %h exp %h", got, {1'b1, 1'b0, 2'd0, BG}); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (got !== 30'h0) begin errors++; $display("FAIL blanking got %h exp 0", got); end
    endtask

    task automatic test_config();
        step(0, 0, 0, 1, 2'd0, 2'd3, 1, 0);
        step(0, 0, 0, 1, 2'd3, 2'd0, 1, 0);
        step(1, 4'b1001, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (top_layer !== 2'd3 || got !== out_e) begin errors++; $display("FAIL shadow_not_active got %h exp %h", got, out_e); end
        checks++;
        if (cfg_pending !== 1'b0) begin errors++; $display("FAIL pending_clear got %b exp 0", cfg_pending); end
        step(1, 4'b1001, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (top_layer !== 2'd0 || got !== out_e) begin errors++; $display("FAIL swap_active got %h exp %h", got, out_e); end
    endtask

    task automatic test_pending_set();
        step(0, 0, 0, 1, 2'd0, 2'd0, 1, 0);
        checks++;
        if (cfg_pending !== 1'b1) begin errors++; $display("FAIL pending_set got %b exp 1", cfg_pending); end
    endtask

    task automatic test_blend();
        step(0, 0, 0, 1, 2'd3, 2'd3, 1, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        rgb_in = {24'hFF2040, 24'h55AA11, 24'h003306, 24'h777777};
        step(1, 4'b1010, 0, 0, 0, 0, 0, 0);
        step(1, 4'b1000, 0, 0, 0, 0, 0, 0);
        checks++;
        if (red !== 8'h7F || got !== out_e) begin errors++; $display("FAIL blend_runnerup got %h exp %h", got, out_e); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (red !== 8'h80 || blue !== 8'h60 || got !== out_e) begin errors++; $display("FAIL blend_bg got %h exp %h", got, out_e); end
    endtask

    task automatic test_tie();
        step(0, 0, 0, 1, 2'd1, 2'd2, 1, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0110, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2'd2, 2'd2, 0, 0);
        checks++;
        if (top_layer !== 2'd2 || got !== out_e) begin errors++; $display("FAIL tie_high_index got %h exp %h", got, out_e); end
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 4'b0110, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 2'd2, 2'd2, 1, 0);
        checks++;
        if (top_layer !== 2'd1 || got !== out_e) begin errors++; $display("FAIL disabled_layer got %h exp %h", got, out_e); end
        step(1, 4'b0110, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        checks++;
        if (top_layer !== 2'd1 || cfg_pending !== 1'b0 || got !== out_e) begin
            errors++; $display("FAIL same_cycle_wr_swap got %h/%b exp %h/0", got, cfg_pending, out_e);
        end
        step(1, 4'b0110, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (top_layer !== 2'd2 || got !== out_e) begin errors++; $display("FAIL late_swap got %h exp %h", got, out_e); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rgb_in = {$urandom, $urandom, $urandom};
            step($urandom_range(0, 3) != 0, 4'($urandom), $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                 2'($urandom), 2'($urandom), $urandom_range(0, 4) != 0, 1'($urandom));
            checks++;
            if (got !== out_e || cfg_pending !== m_pend) begin
                errors++; $display("FAIL random[%0d] got %h/%b exp %h/%b", n, got, cfg_pending, out_e, m_pend);
            end
        end
    endtask

    task automatic test_reset_mid();
        rgb_in = {24'h123456, 24'h789ABC, 24'hDEF012, 24'h345678};
        step(0, 0, 0, 1, 2'd3, 2'd0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0);
        step(1, 4'b1111, 0, 0, 0, 0, 0, 0);
        step(1, 4'b1111, 0, 1, 2'd1, 2'd0, 0, 0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (got !== 30'h0 || cfg_pending !== 1'b0) begin
            errors++; $display("FAIL async_reset got %h/%b exp 0/0", got, cfg_pending);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1, 4'b1111, 0, 0, 0, 0, 0, 0);
        checks++;
        if (pix_valid_out !== 1'b0) begin errors++; $display("FAIL post_reset_early got %b exp 0", pix_valid_out); end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (got !== {1'b1, 1'b1, 2'd3, 24'h123456} || got !== out_e) begin
            errors++; $display("FAIL post_reset_defaults got %h exp %h", got, {1'b1, 1'b1, 2'd3, 24'h123456});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; pix_valid_in = 0; req = 0; rgb_in = '0; frame_start = 0;
        cfg_wr = 0; cfg_layer = 0; cfg_rank = 0; cfg_en = 0; cfg_blend = 0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic();
        test_bg_blank();
        test_config();
        test_pending_set();
        test_blend();
        test_tie();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
